// File: rtl/oa_tree_sequencer_if.sv
// oa_tree_sequencer_if: handshake, operand, tree-digit and result signals of the
// OA adder-tree frame sequencer.
//   slave  modport: sequencer side (accepts frames, drives tree digits, presents result)
//   master modport: environment side (staging logic, adder tree, result consumer)
// Signals:
//   in_valid/in_ready    operand frame handshake
//   op_p/op_n            NumOps operands of NDigits signed digits, operand i at [i*NDigits +: NDigits]
//   dig_p/dig_n          current digit of each operand to the tree
//   tree_rst             active-low reset to the tree OA instances
//   z_p/z_n              tree output digit
//   res_valid/res_ready  result handshake
//   res_p/res_n          collected result, MSB = first digit out of the tree
//   digit_err            illegal (1,1) digit captured in the current frame
//   busy                 sequencer not idle
interface oa_tree_sequencer_if #(
  parameter int unsigned NumOps     = 8,
  parameter int unsigned NDigits    = 8,
  parameter int unsigned TreeLevels = 3,
  parameter int unsigned OaDelay    = 2
);
  localparam int unsigned ResDigits = NDigits + TreeLevels * OaDelay;

  logic                        in_valid;
  logic                        in_ready;
  logic [NumOps*NDigits-1:0]   op_p;
  logic [NumOps*NDigits-1:0]   op_n;
  logic [NumOps-1:0]           dig_p;
  logic [NumOps-1:0]           dig_n;
  logic                        tree_rst;
  logic                        z_p;
  logic                        z_n;
  logic                        res_valid;
  logic                        res_ready;
  logic [ResDigits-1:0]        res_p;
  logic [ResDigits-1:0]        res_n;
  logic                        digit_err;
  logic                        busy;

  modport slave (
    input  in_valid, op_p, op_n, z_p, z_n, res_ready,
    output in_ready, dig_p, dig_n, tree_rst, res_valid, res_p, res_n, digit_err, busy
  );

  modport master (
    output in_valid, op_p, op_n, z_p, z_n, res_ready,
    input  in_ready, dig_p, dig_n, tree_rst, res_valid, res_p, res_n, digit_err, busy
  );
endinterface

// File: rtl/oa_tree_sequencer.sv
// oa_tree_sequencer: frame sequencer for the online-arithmetic adder tree.
// Accepts a frame of NumOps signed-digit operands, pulses the tree reset for one
// cycle, streams the operands MSD first, flushes the tree online delay with zero
// digits and collects the serial tree output into a parallel signed-digit word.
// Ports:
//   clk_i   clock, all state on rising edge
//   rst_ni  asynchronous active-low reset
//   bus     oa_tree_sequencer_if.slave (frame, tree digit and result signals)
module oa_tree_sequencer #(
  parameter int unsigned NumOps     = 8,
  parameter int unsigned NDigits    = 8,
  parameter int unsigned TreeLevels = 3,
  parameter int unsigned OaDelay    = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  oa_tree_sequencer_if.slave  bus
);
  localparam int unsigned TreeDelay = TreeLevels * OaDelay;
  localparam int unsigned ResDigits = NDigits + TreeDelay;
  localparam int unsigned RunLen    = NDigits + 2 * TreeDelay;
  localparam int unsigned CntW      = $clog2(RunLen);
  localparam int unsigned DigW      = $clog2(NDigits);

  localparam logic [CntW-1:0] LastCnt = CntW'(RunLen - 1);
  localparam logic [CntW-1:0] CapCnt  = CntW'(TreeDelay);
  localparam logic [CntW-1:0] DigLast = CntW'(NDigits - 1);
  localparam logic [DigW-1:0] DigMsb  = DigW'(NDigits - 1);

  typedef enum logic [1:0] {StIdle, StClr, StRun, StDone} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [NumOps*NDigits-1:0] opp_q, opp_d, opn_q, opn_d;
  logic [NumOps-1:0]         dig_p_q, dig_p_d, dig_n_q, dig_n_d;
  logic [ResDigits-1:0]      res_p_q, res_p_d, res_n_q, res_n_d;
  logic                      err_q, err_d;

  // Digits are registered, so select the digit for the count of the next cycle.
  logic [CntW-1:0]   dnext;
  logic [DigW-1:0]   dsel;
  logic [NumOps-1:0] sel_p, sel_n;

  assign dnext = (state_q == StRun) ? cnt_q + CntW'(1) : '0;
  assign dsel  = DigMsb - dnext[DigW-1:0];

  for (genvar gi = 0; gi < NumOps; gi++) begin : g_sel
    logic [NDigits-1:0] wp, wn;
    assign wp        = opp_q[gi*NDigits +: NDigits];
    assign wn        = opn_q[gi*NDigits +: NDigits];
    assign sel_p[gi] = wp[dsel];
    assign sel_n[gi] = wn[dsel];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opp_d   = opp_q;
    opn_d   = opn_q;
    dig_p_d = '0;
    dig_n_d = '0;
    res_p_d = res_p_q;
    res_n_d = res_n_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          opp_d   = bus.op_p;
          opn_d   = bus.op_n;
          res_p_d = '0;
          res_n_d = '0;
          err_d   = 1'b0;
          state_d = StClr;
        end
      end
      StClr: begin
        cnt_d   = '0;
        dig_p_d = sel_p;
        dig_n_d = sel_n;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q < DigLast) begin
          dig_p_d = sel_p;
          dig_n_d = sel_n;
        end
        // Tree output is meaningful only after the full online delay.
        if (cnt_q >= CapCnt) begin
          res_p_d = {res_p_q[ResDigits-2:0], bus.z_p};
          res_n_d = {res_n_q[ResDigits-2:0], bus.z_n};
          if (bus.z_p && bus.z_n) err_d = 1'b1;
        end
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opp_q   <= '0;
      opn_q   <= '0;
      dig_p_q <= '0;
      dig_n_q <= '0;
      res_p_q <= '0;
      res_n_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opp_q   <= opp_d;
      opn_q   <= opn_d;
      dig_p_q <= dig_p_d;
      dig_n_q <= dig_n_d;
      res_p_q <= res_p_d;
      res_n_q <= res_n_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.res_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.dig_p     = dig_p_q;
  assign bus.dig_n     = dig_n_q;
  assign bus.res_p     = res_p_q;
  assign bus.res_n     = res_n_q;
  assign bus.digit_err = err_q;
  // Combinational from rst_ni so the tree resets asynchronously with the sequencer.
  assign bus.tree_rst  = rst_ni & (state_q != StClr);
endmodule

// File: tb/tb_oa_tree_sequencer.sv
// tb_oa_tree_sequencer: directed self-checking bench for oa_tree_sequencer.
// The bench plays the adder tree: it feeds the hand-computed result digits on z
// at the capture cycles and checks digit streaming, timing and the collected word.
module tb_oa_tree_sequencer;
  localparam int RES = 14;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_bad    = 0;

  oa_tree_sequencer_if bus ();

  oa_tree_sequencer u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One frame on a fixed timeline from the acceptance edge. sum256 is the exact
  // operand sum in units of 2^-8; res bit 3 carries weight 2^-8.
  task automatic run_frame(input logic [63:0] opp, input logic [63:0] opn, input int sum256,
                           input int stall, input int err_j);
    logic [RES-1:0] ep, en, zsp, zsn;
    logic [7:0]     edp, edn;
    logic [63:0]    sp, sn;
    ep = '0;
    en = '0;
    if (sum256 >= 0) ep = RES'(sum256 * 8);
    else             en = RES'(-sum256 * 8);
    if (err_j >= 0) begin
      ep = ep | (RES'(1) << (RES - 1 - (err_j - 6)));
      en = en | (RES'(1) << (RES - 1 - (err_j - 6)));
    end
    zsp = ep;
    zsn = en;
    bus.res_ready = (stall == 0);
    bus.op_p      = opp;
    bus.op_n      = opn;
    bus.in_valid  = 1'b1;
    check_val("idle_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_val("clr_tree_rst", 32'(bus.tree_rst), 32'd0);
    check_val("clr_dig", 32'({bus.dig_p, bus.dig_n}), 32'd0);
    check_val("clr_err", 32'(bus.digit_err), 32'd0);
    check_val("clr_busy_rdy", 32'({bus.busy, bus.in_ready}), 32'b10);
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      edp = '0;
      edn = '0;
      if (j < 8) begin
        for (int i = 7; i >= 0; i--) begin
          sp  = opp >> (i * 8 + 7 - j);
          sn  = opn >> (i * 8 + 7 - j);
          edp = {edp[6:0], sp[0]};
          edn = {edn[6:0], sn[0]};
        end
      end
      check_val("run_dig_p", 32'(bus.dig_p), 32'(edp));
      check_val("run_dig_n", 32'(bus.dig_n), 32'(edn));
      if (j == 0)  check_val("run_tree_rst", 32'(bus.tree_rst), 32'd1);
      if (j == 19) check_val("run_last_valid", 32'(bus.res_valid), 32'd0);
      if (j >= 6) begin
        bus.z_p = zsp[RES-1];
        bus.z_n = zsn[RES-1];
        zsp     = zsp << 1;
        zsn     = zsn << 1;
      end else begin
        bus.z_p = 1'b0;
        bus.z_n = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.z_p = 1'b0;
    bus.z_n = 1'b0;
    check_val("done_valid", 32'(bus.res_valid), 32'd1);
    check_val("done_ready", 32'(bus.in_ready), 32'd0);
    check_val("done_res_p", 32'(bus.res_p), 32'(ep));
    check_val("done_res_n", 32'(bus.res_n), 32'(en));
    check_val("done_err", 32'(bus.digit_err), 32'(err_j >= 0));
    if (stall > 0) begin
      bus.in_valid = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check_val("stall_valid", 32'(bus.res_valid), 32'd1);
        check_val("stall_ready", 32'(bus.in_ready), 32'd0);
        check_val("stall_res", 32'({bus.res_p, bus.res_n}), 32'({ep, en}));
      end
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_val("post_ready", 32'(bus.in_ready), 32'd1);
    check_val("post_valid", 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_p      = '0;
    bus.op_n      = '0;
    bus.z_p       = 1'b0;
    bus.z_n       = 1'b0;
    bus.res_ready = 1'b1;
    #1;
    check_val("rst_tree_rst", 32'(bus.tree_rst), 32'd0);
    check_val("rst_valid_busy", 32'({bus.res_valid, bus.busy}), 32'd0);
    check_val("rst_dig", 32'({bus.dig_p, bus.dig_n}), 32'd0);
    check_val("rst_res", 32'({bus.res_p, bus.res_n}), 32'd0);
    check_val("rst_err", 32'(bus.digit_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rel_ready", 32'(bus.in_ready), 32'd1);
    check_val("rel_tree_rst", 32'(bus.tree_rst), 32'd1);

    // All zero.
    run_frame(64'h0, 64'h0, 0, 0, -1);
    // op0 = 0.5.
    run_frame(64'h80, 64'h0, 128, 0, -1);
    // Eight operands of 255/256: sum 7.96875.
    run_frame(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2040, 0, -1);
    // 0.75 - 0.25 + 2^-8 = 0.50390625, with 10-cycle result stall.
    run_frame(64'h0100_0000_0000_00C0, 64'h0000_0000_0000_4000, 129, 10, -1);

    // Reset at RUN cnt=5 aborts the frame.
    bus.op_p     = 64'h80;
    bus.op_n     = '0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_val("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("abort_tree_rst", 32'(bus.tree_rst), 32'd0);
    check_val("abort_valid_busy", 32'({bus.res_valid, bus.busy}), 32'd0);
    check_val("abort_dig", 32'({bus.dig_p, bus.dig_n}), 32'd0);
    check_val("abort_res", 32'({bus.res_p, bus.res_n}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("abort_ready", 32'(bus.in_ready), 32'd1);
    run_frame(64'h80, 64'h0, 128, 0, -1);

    // Forced (1,1) tree digit at capture cnt=10, then cleared on next acceptance.
    run_frame(64'h0, 64'h0, 0, 0, 10);
    run_frame(64'h80, 64'h0, 128, 0, -1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
